// File: rtl/pack_pkg.sv
// Shared types and constants for the packet TX buffer.
package pack_pkg;

  localparam int unsigned PKG_DATA_WIDTH = 64;
  localparam int unsigned KEEP_W         = PKG_DATA_WIDTH / 8;
  localparam int unsigned EMPTY_W        = 3;
  // Sized for the default ADDR_WIDTH of 11 (len is ADDR_WIDTH+1 bits).
  localparam int unsigned DESC_LEN_W     = 12;

  typedef struct packed {
    logic [DESC_LEN_W-1:0] len;
    logic [EMPTY_W-1:0]    empty;
  } pkt_desc_t;

  typedef enum logic [1:0] {WIdle, WPkt, WDrop} wr_state_e;
  typedef enum logic {RIdle, RPkt} rd_state_e;

  function automatic logic [KEEP_W-1:0] eop_keep(input logic [EMPTY_W-1:0] empty,
                                                 input logic big_endian);
    return big_endian ? (8'hFF << empty) : (8'hFF >> empty);
  endfunction

endpackage

// File: rtl/util_sdp_ram.sv
// Simple dual-port RAM with registered read; read-during-write returns old data.
module util_sdp_ram #(
  parameter int unsigned Width     = 8,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [Width-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [Width-1:0]     rd_data_o
);

  logic [Width-1:0] mem_q [2**AddrWidth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/pack_tx_buffer.sv
// Store-and-forward packet buffer: commits whole packets on eop and replays them to the MAC
// under ready/valid, dropping packets that cannot be admitted.
module pack_tx_buffer
  import pack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 11,
  parameter int unsigned DESC_ADDR_WIDTH = 6,
  parameter int unsigned MAX_PKT_WORDS   = 1024,
  parameter bit          DATA_BIG_ENDIAN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       din_sop,
  input  logic                       din_eop,
  input  logic                       din_valid,
  input  logic [DATA_WIDTH-1:0]      din_data,
  input  logic [EMPTY_W-1:0]         din_empty,
  input  logic                       dout_ready,
  output logic                       dout_sop,
  output logic                       dout_eop,
  output logic                       dout_valid,
  output logic [DATA_WIDTH-1:0]      dout_data,
  output logic [KEEP_W-1:0]          dout_keep,
  output logic [15:0]                drop_cnt,
  output logic [15:0]                err_cnt,
  output logic [ADDR_WIDTH:0]        word_used,
  output logic [DESC_ADDR_WIDTH:0]   pkt_used
);

  localparam int unsigned PW  = ADDR_WIDTH + 1;
  localparam int unsigned DPW = DESC_ADDR_WIDTH + 1;
  localparam int unsigned EW  = DATA_WIDTH + KEEP_W + 2;
  localparam logic [PW-1:0]  PtrOne     = PW'(1);
  localparam logic [DPW-1:0] DPtrOne    = DPW'(1);
  localparam logic [PW-1:0]  MaxWords   = PW'(MAX_PKT_WORDS);
  localparam logic [PW-1:0]  SlackWords = PW'((1 << ADDR_WIDTH) - MAX_PKT_WORDS);

  wr_state_e wr_st_q, wr_st_d;
  rd_state_e rd_st_q, rd_st_d;

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, commit_q, commit_d, wcnt_q, wcnt_d, rd_ptr_q, rcnt_q;
  logic [PW-1:0]  ram_waddr, desc_len, used_commit, rd_len;
  logic [DPW-1:0] dwptr_q, drptr_q, desc_cnt, pkt_used_q;
  logic [15:0]    drop_q, err_q;
  logic           ram_we, desc_push, desc_pop, err_inc, drop_inc, admit, desc_full, desc_avail;
  logic           issue, rd_last, credit_ok, out_pop, pkt_sent;
  logic           infl_q, infl_sop_q, infl_eop_q;
  logic [KEEP_W-1:0]     infl_keep_q;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [EW-1:0]  sk0_q, sk0_d, sk1_q, sk1_d, new_ent;
  logic [1:0]     skc_q, skc_d;
  pkt_desc_t      desc_wr, desc_rd;

  assign desc_cnt    = dwptr_q - drptr_q;
  assign desc_full   = desc_cnt[DESC_ADDR_WIDTH];
  assign desc_avail  = (desc_cnt != '0);
  // Admission reserves a whole max-size packet, so the write side never laps unread words.
  assign used_commit = commit_q - rd_ptr_q;
  assign admit       = (used_commit <= SlackWords) && !desc_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_st_q <= WIdle;
    else        wr_st_q <= wr_st_d;
  end

  always_comb begin
    wr_st_d   = wr_st_q;
    wr_ptr_d  = wr_ptr_q;
    commit_d  = commit_q;
    wcnt_d    = wcnt_q;
    ram_we    = 1'b0;
    ram_waddr = wr_ptr_q;
    desc_push = 1'b0;
    desc_len  = wcnt_q + PtrOne;
    err_inc   = 1'b0;
    drop_inc  = 1'b0;
    if (din_valid) begin
      if (din_sop) begin
        // A sop in any state abandons uncommitted words and restarts admission.
        err_inc  = (wr_st_q == WPkt);
        wr_ptr_d = commit_q;
        if (admit) begin
          ram_we    = 1'b1;
          ram_waddr = commit_q;
          wr_ptr_d  = commit_q + PtrOne;
          wcnt_d    = PtrOne;
          if (din_eop) begin
            desc_push = 1'b1;
            desc_len  = PtrOne;
            commit_d  = commit_q + PtrOne;
            wr_st_d   = WIdle;
          end else begin
            wr_st_d = WPkt;
          end
        end else begin
          drop_inc = 1'b1;
          wr_st_d  = din_eop ? WIdle : WDrop;
        end
      end else begin
        unique case (wr_st_q)
          WIdle: err_inc = 1'b1;
          WPkt: begin
            if (wcnt_q == MaxWords) begin
              wr_ptr_d = commit_q;
              err_inc  = 1'b1;
              wr_st_d  = din_eop ? WIdle : WDrop;
            end else begin
              ram_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + PtrOne;
              wcnt_d   = wcnt_q + PtrOne;
              if (din_eop) begin
                desc_push = 1'b1;
                commit_d  = wr_ptr_q + PtrOne;
                wr_st_d   = WIdle;
              end
            end
          end
          WDrop: if (din_eop) wr_st_d = WIdle;
          default: wr_st_d = WIdle;
        endcase
      end
    end
  end

  assign desc_wr.len   = DESC_LEN_W'(desc_len);
  assign desc_wr.empty = din_empty;
  assign rd_len        = PW'(desc_rd.len);
  assign rd_last       = (rcnt_q == rd_len - PtrOne);
  assign out_pop       = dout_valid && dout_ready;
  // Skid holds two words; count the RAM word in flight against that space.
  assign credit_ok     = ({1'b0, skc_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, out_pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_st_q <= RIdle;
    else        rd_st_q <= rd_st_d;
  end

  always_comb begin
    rd_st_d = rd_st_q;
    unique case (rd_st_q)
      RIdle:   if (desc_avail) rd_st_d = RPkt;
      RPkt:    if (issue && rd_last) rd_st_d = RIdle;
      default: rd_st_d = RIdle;
    endcase
  end

  always_comb begin
    desc_pop = (rd_st_q == RIdle) && desc_avail;
    issue    = (rd_st_q == RPkt) && credit_ok;
  end

  assign new_ent = {infl_sop_q, infl_eop_q, infl_keep_q, ram_rdata};

  always_comb begin
    sk0_d = sk0_q;
    sk1_d = sk1_q;
    skc_d = skc_q;
    case ({out_pop, infl_q})
      2'b01: begin
        if (skc_q == 2'd0) sk0_d = new_ent;
        else               sk1_d = new_ent;
        skc_d = skc_q + 2'd1;
      end
      2'b10: begin
        sk0_d = sk1_q;
        skc_d = skc_q - 2'd1;
      end
      2'b11: begin
        if (skc_q == 2'd1) begin
          sk0_d = new_ent;
        end else begin
          sk0_d = sk1_q;
          sk1_d = new_ent;
        end
      end
      default: ;
    endcase
  end

  assign pkt_sent = out_pop && sk0_q[EW-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      commit_q    <= '0;
      wcnt_q      <= '0;
      rd_ptr_q    <= '0;
      rcnt_q      <= '0;
      dwptr_q     <= '0;
      drptr_q     <= '0;
      pkt_used_q  <= '0;
      drop_q      <= '0;
      err_q       <= '0;
      infl_q      <= 1'b0;
      infl_sop_q  <= 1'b0;
      infl_eop_q  <= 1'b0;
      infl_keep_q <= '0;
      sk0_q       <= '0;
      sk1_q       <= '0;
      skc_q       <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      wcnt_q   <= wcnt_d;
      if (desc_push) dwptr_q <= dwptr_q + DPtrOne;
      if (desc_pop) begin
        drptr_q <= drptr_q + DPtrOne;
        rcnt_q  <= '0;
      end
      if (issue) begin
        rd_ptr_q    <= rd_ptr_q + PtrOne;
        rcnt_q      <= rcnt_q + PtrOne;
        infl_sop_q  <= (rcnt_q == '0);
        infl_eop_q  <= rd_last;
        infl_keep_q <= rd_last ? eop_keep(desc_rd.empty, DATA_BIG_ENDIAN) : '1;
      end
      infl_q <= issue;
      if (desc_push && !pkt_sent)      pkt_used_q <= pkt_used_q + DPtrOne;
      else if (!desc_push && pkt_sent) pkt_used_q <= pkt_used_q - DPtrOne;
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (err_inc && err_q != 16'hFFFF)   err_q  <= err_q + 16'd1;
      sk0_q <= sk0_d;
      sk1_q <= sk1_d;
      skc_q <= skc_d;
    end
  end

  util_sdp_ram #(
    .Width     (DATA_WIDTH),
    .AddrWidth (ADDR_WIDTH)
  ) u_data_ram (
    .clk_i     (clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (ram_waddr[ADDR_WIDTH-1:0]),
    .wr_data_i (din_data),
    .rd_en_i   (issue),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (ram_rdata)
  );

  util_sdp_ram #(
    .Width     ($bits(pkt_desc_t)),
    .AddrWidth (DESC_ADDR_WIDTH)
  ) u_desc_ram (
    .clk_i     (clk),
    .wr_en_i   (desc_push),
    .wr_addr_i (dwptr_q[DESC_ADDR_WIDTH-1:0]),
    .wr_data_i (desc_wr),
    .rd_en_i   (desc_pop),
    .rd_addr_i (drptr_q[DESC_ADDR_WIDTH-1:0]),
    .rd_data_o (desc_rd)
  );

  assign dout_valid = (skc_q != 2'd0);
  assign dout_sop   = dout_valid && sk0_q[EW-1];
  assign dout_eop   = dout_valid && sk0_q[EW-2];
  assign dout_keep  = dout_valid ? sk0_q[EW-3 -: KEEP_W] : '0;
  assign dout_data  = sk0_q[DATA_WIDTH-1:0];
  assign drop_cnt   = drop_q;
  assign err_cnt    = err_q;
  assign word_used  = wr_ptr_q - rd_ptr_q;
  assign pkt_used   = pkt_used_q;

endmodule

// File: tb/tb_pack_tx_buffer.sv
// Directed bench for pack_tx_buffer: latency, stalls, admission drops, framing errors,
// pointer wrap and asynchronous reset, checked against a bench-side scoreboard.
module tb_pack_tx_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din_sop, din_eop, din_valid, dout_ready;
  logic [63:0] din_data;
  logic [2:0]  din_empty;

  logic        dout_sop, dout_eop, dout_valid;
  logic [63:0] dout_data;
  logic [7:0]  dout_keep;
  logic [15:0] drop_cnt, err_cnt;
  logic [11:0] word_used;
  logic [6:0]  pkt_used;

  logic        le_sop, le_eop, le_valid;
  logic [63:0] le_data;
  logic [7:0]  le_keep;
  logic [15:0] le_drop, le_err;
  logic [11:0] le_word_used;
  logic [6:0]  le_pkt_used;

  int          checks = 0;
  int          errors = 0;
  logic [73:0] exp_q[$];
  logic        stall = 1'b0;
  logic [73:0] held = '0;

  always #5 clk = ~clk;

  pack_tx_buffer #(.DATA_BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .din_sop(din_sop), .din_eop(din_eop), .din_valid(din_valid),
    .din_data(din_data), .din_empty(din_empty), .dout_ready(dout_ready),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_valid(dout_valid), .dout_data(dout_data),
    .dout_keep(dout_keep), .drop_cnt(drop_cnt), .err_cnt(err_cnt), .word_used(word_used),
    .pkt_used(pkt_used)
  );

  pack_tx_buffer #(.DATA_BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .din_sop(din_sop), .din_eop(din_eop), .din_valid(din_valid),
    .din_data(din_data), .din_empty(din_empty), .dout_ready(dout_ready),
    .dout_sop(le_sop), .dout_eop(le_eop), .dout_valid(le_valid), .dout_data(le_data),
    .dout_keep(le_keep), .drop_cnt(le_drop), .err_cnt(le_err), .word_used(le_word_used),
    .pkt_used(le_pkt_used)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: sample at negedge, check stall stability, choose ready, score accepted word.
  // mode 0: ready low, 1: toggle, 2: random ~75%, 3: ready high.
  task automatic tick(input int mode);
    logic [73:0] cur;
    logic [73:0] e;
    @(negedge clk);
    cur = {dout_sop, dout_eop, dout_keep, dout_data};
    if (stall) chk("stable", 128'({dout_valid, cur}), 128'({1'b1, held}));
    case (mode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = ~dout_ready;
      2:       dout_ready = ($urandom_range(0, 3) != 0);
      default: dout_ready = 1'b1;
    endcase
    stall = dout_valid && !dout_ready;
    held  = cur;
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 128'(cur), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("word", 128'(cur), 128'(e));
      end
    end
  endtask

  task automatic put(input logic sop, input logic eop, input logic [63:0] data,
                     input logic [2:0] empty, input logic keep_it);
    logic [7:0] k;
    din_valid = 1'b1;
    din_sop   = sop;
    din_eop   = eop;
    din_data  = data;
    din_empty = empty;
    k = eop ? (8'hFF << empty) : 8'hFF;
    if (keep_it) exp_q.push_back({sop, eop, k, data});
  endtask

  task automatic idle_in();
    din_valid = 1'b0;
    din_sop   = 1'b0;
    din_eop   = 1'b0;
  endtask

  task automatic drain(input int mode, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(mode);
      idle_in();
      n++;
    end
    chk("drain_left", 128'(exp_q.size()), 128'(0));
    tick(3);
    tick(3);
  endtask

  initial begin
    int go;
    rst_n = 1'b0;
    dout_ready = 1'b0;
    din_data = '0;
    din_empty = '0;
    idle_in();
    #1;
    chk("rst_out", 128'({dout_sop, dout_eop, dout_valid, dout_keep, dout_data, drop_cnt,
                         err_cnt, word_used, pkt_used}), 128'(0));
    chk("rst_out_le", 128'({le_sop, le_eop, le_valid, le_keep, le_pkt_used}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1-word packet, empty=3: visible three cycles after the eop edge
    tick(3);
    put(1'b1, 1'b1, 64'h1122_3344_5566_7788, 3'd3, 1'b1);
    tick(3);
    idle_in();
    tick(3);
    tick(3);
    chk("lat_early", 128'(dout_valid), 128'(0));
    tick(3);
    chk("lat_out", 128'({dout_valid, dout_sop, dout_eop, dout_keep}), 128'({3'b111, 8'hF8}));
    chk("lat_le", 128'({le_valid, le_sop, le_eop, le_keep}), 128'({3'b111, 8'h1F}));
    tick(3);
    tick(3);
    chk("p1_used", 128'({word_used, pkt_used}), 128'(0));

    // 100-word packet replayed under alternating ready
    for (int i = 0; i < 100; i++) begin
      tick(0);
      put(i == 0, i == 99, 64'hA000_0000_0000_0000 + 64'(i), 3'd0, 1'b1);
    end
    tick(0);
    idle_in();
    drain(1, 1000);
    chk("p100_cnt", 128'({drop_cnt, err_cnt, pkt_used}), 128'(0));

    // three 1024-word packets with ready low: third cannot be admitted
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1024; i++) begin
        tick(0);
        put(i == 0, i == 1023, {16'hB000 + 16'(p), 48'(i)}, 3'd0, p < 2);
      end
    end
    tick(0);
    idle_in();
    repeat (4) tick(0);
    chk("full_drop", 128'(drop_cnt), 128'(1));
    chk("full_pkts", 128'(pkt_used), 128'(2));
    drain(3, 5000);
    chk("full_after", 128'({word_used, pkt_used, err_cnt}), 128'(0));

    // sop at word 10 of an open packet, then a 5-word packet
    for (int i = 0; i < 10; i++) begin
      tick(3);
      put(i == 0, 1'b0, 64'hDEAD_0000_0000_0000 + 64'(i), 3'd0, 1'b0);
    end
    for (int j = 0; j < 5; j++) begin
      tick(3);
      put(j == 0, j == 4, 64'hC500_0000_0000_0000 + 64'(j), (j == 4) ? 3'd5 : 3'd0, 1'b1);
    end
    tick(3);
    idle_in();
    drain(3, 200);
    chk("sop_err", 128'(err_cnt), 128'(1));
    chk("sop_used", 128'({word_used, pkt_used}), 128'(0));

    // stray word outside a packet
    tick(3);
    put(1'b0, 1'b0, 64'h5757_5757_5757_5757, 3'd0, 1'b0);
    tick(3);
    idle_in();
    repeat (4) tick(3);
    chk("stray_err", 128'({err_cnt, dout_valid}), 128'({16'd2, 1'b0}));

    // pointer wrap: 500 x 37-word packets, gapped input, random ready
    for (int p = 0; p < 500; p++) begin
      for (int w = 0; w < 37; w++) begin
        do begin
          tick(2);
          go = int'($urandom_range(0, 1));
          if (go == 0) idle_in();
        end while (go == 0);
        put(w == 0, w == 36, {16'(p), 16'(w), 32'hC0DE_0000 + 32'(p * 37 + w)},
            (w == 36) ? 3'(p % 8) : 3'd0, 1'b1);
      end
    end
    tick(2);
    idle_in();
    drain(2, 20000);
    chk("wrap_used", 128'({word_used, pkt_used}), 128'(0));
    chk("wrap_cnt", 128'({drop_cnt, err_cnt}), 128'({16'd1, 16'd2}));

    // asynchronous reset in the middle of an output packet
    for (int i = 0; i < 8; i++) begin
      tick(0);
      put(i == 0, i == 7, 64'hEEEE_0000_0000_0000 + 64'(i), 3'd0, 1'b1);
    end
    tick(0);
    idle_in();
    repeat (4) tick(0);
    tick(3);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 128'({dout_sop, dout_eop, dout_valid, dout_keep, dout_data, drop_cnt,
                           err_cnt, word_used, pkt_used}), 128'(0));
    exp_q.delete();
    stall = 1'b0;
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(3);
      put(i == 0, i == 2, 64'h7777_0000_0000_0000 + 64'(i), (i == 2) ? 3'd2 : 3'd0, 1'b1);
    end
    tick(3);
    idle_in();
    drain(3, 100);
    chk("post_rst", 128'({drop_cnt, err_cnt, word_used, pkt_used, dout_valid}), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
